// File: rtl/led_blink_sequencer_pkg.sv
// Shared types and default constants for the LED blink sequencer and its tick prescaler.
package led_blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam int DEF_TICK_DIV = 50_000;
  localparam int DEF_LEN_W    = 10;
  localparam int DEF_NUM_W    = 4;

endpackage

// File: rtl/led_blink_sequencer_if.sv
// Command/status bundle between control logic and the blink sequencer.
// The abort signal exists only when BLINK_ABORT_EN is defined.
interface led_blink_sequencer_if
  import led_blink_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int NUM_W = DEF_NUM_W
) ();

  logic             start;
  logic [NUM_W-1:0] blink_num;
  logic [LEN_W-1:0] on_len;
  logic [LEN_W-1:0] off_len;
`ifdef BLINK_ABORT_EN
  logic             abort;
`endif
  logic             busy;
  logic             done;
  logic             led;

  modport master (
    output start, blink_num, on_len, off_len,
`ifdef BLINK_ABORT_EN
    output abort,
`endif
    input  busy, done, led
  );

  modport slave (
    input  start, blink_num, on_len, off_len,
`ifdef BLINK_ABORT_EN
    input  abort,
`endif
    output busy, done, led
  );

endinterface

// File: rtl/led_blink_sequencer_tick_prescaler.sv
// Enable-gated, clearable divider: tick is high in the cycle the count reaches TICK_DIV-1.
module tick_prescaler #(
  parameter int TICK_DIV = led_blink_pkg::DEF_TICK_DIV
) (
  input  logic Clk50M,
  input  logic Rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_MAX);

  // clr has priority so a phase change always restarts a full tick period
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk50M or posedge Rst) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blink_sequencer.sv
// Commanded LED blink bursts: N on/off blinks with tick-based phase lengths.
// Define BLINK_ABORT_EN to add the abort input that cuts a burst short.
module led_blink_sequencer
  import led_blink_pkg::*;
#(
  parameter int   TICK_DIV     = DEF_TICK_DIV,
  parameter int   LEN_W        = DEF_LEN_W,
  parameter int   NUM_W        = DEF_NUM_W,
  parameter logic LED_ON_LEVEL = 1'b1
) (
  input  logic Clk50M,
  input  logic Rst,
  led_blink_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] on_len_q, on_len_d;
  logic [LEN_W-1:0] off_len_q, off_len_d;
  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic [NUM_W-1:0] rem_q, rem_d;
  logic             led_q, led_d;

  logic             presc_en, presc_clr, tick;
  logic [LEN_W-1:0] phase_len, phase_last;
  logic             phase_end;
  logic             abort_req;

`ifdef BLINK_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .Clk50M (Clk50M),
    .Rst    (Rst),
    .en     (presc_en),
    .clr    (presc_clr),
    .tick   (tick)
  );

  // Zero lengths behave as one tick, so the last-tick index never underflows
  assign phase_len  = (state_q == ST_ON) ? on_len_q : off_len_q;
  assign phase_last = (phase_len == '0) ? '0 : phase_len - 1'b1;
  assign phase_end  = tick && (len_cnt_q == phase_last);

  always_comb begin
    state_d   = state_q;
    on_len_d  = on_len_q;
    off_len_d = off_len_q;
    len_cnt_d = len_cnt_q;
    rem_d     = rem_q;
    presc_en  = (state_q == ST_ON) || (state_q == ST_OFF);
    presc_clr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        presc_clr = 1'b1;
        if (bus.start) begin
          on_len_d  = bus.on_len;
          off_len_d = bus.off_len;
          rem_d     = bus.blink_num;
          len_cnt_d = '0;
          state_d   = (bus.blink_num == '0) ? ST_FIN : ST_ON;
        end
      end
      ST_ON: begin
        if (abort_req) begin
          state_d   = ST_FIN;
          len_cnt_d = '0;
          rem_d     = '0;
          presc_clr = 1'b1;
        end else if (phase_end) begin
          state_d   = ST_OFF;
          len_cnt_d = '0;
          presc_clr = 1'b1;
        end else if (tick) begin
          len_cnt_d = len_cnt_q + 1'b1;
        end
      end
      ST_OFF: begin
        if (abort_req) begin
          state_d   = ST_FIN;
          len_cnt_d = '0;
          rem_d     = '0;
          presc_clr = 1'b1;
        end else if (phase_end) begin
          rem_d     = rem_q - 1'b1;
          len_cnt_d = '0;
          presc_clr = 1'b1;
          state_d   = (rem_q != NUM_W'(1)) ? ST_ON : ST_FIN;
        end else if (tick) begin
          len_cnt_d = len_cnt_q + 1'b1;
        end
      end
      ST_FIN: begin
        presc_clr = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    led_d = (state_d == ST_ON) ? LED_ON_LEVEL : ~LED_ON_LEVEL;
  end

  always_ff @(posedge Clk50M or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      on_len_q  <= '0;
      off_len_q <= '0;
      len_cnt_q <= '0;
      rem_q     <= '0;
      led_q     <= ~LED_ON_LEVEL;
    end else begin
      state_q   <= state_d;
      on_len_q  <= on_len_d;
      off_len_q <= off_len_d;
      len_cnt_q <= len_cnt_d;
      rem_q     <= rem_d;
      led_q     <= led_d;
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_FIN);
  assign bus.led  = led_q;

endmodule
